ebus_arb_mux: RTL and testbench
===============================

Name: ebus_arb_mux

Overview:
- Parametrised successor to the flat top-level EBUS data mux.
- Selects one of NDRV EBUS drivers (APR, CON, CRA, CTL, DTE, EDP, IR, MBZ, MTR, PIC, SCD, SHM, VMA, …) by fixed priority, with the lowest index winning.
- Registers the winner's data onto EBUS with 1-cycle latency.
- Adds bus-health monitoring the flat mux lacks: multi-driver contention capture, a saturating contention counter, and a stuck-driver hold timeout.
- Sits in top, between the per-module EBUSdriver outputs and EBUS.data.

Parameters:
- NDRV, 13, number of EBUS driver inputs; index 0 has highest priority.
- W, 36, EBUS data width; bit 0 is the MSB, PDP-10 0:35 numbering.
- CW, 8, width of the contention counter.
- MAXHOLD, 1024, consecutive cycles one owner may drive before timeout; 0 disables the timeout.

Ports:
- clk, input, 1, system clock.
- CROBAR, input, 1, reset. Synchronous, active-high.
- drvDriving, input, NDRV, per-driver "driving" request.
- drvData, input, NDRV*W, per-driver data, flattened; driver i occupies slice [i*W +: W].
- clrErr, input, 1, one-cycle pulse that clears the sticky error state.
- data, output, W, registered EBUS data.
- valid, output, 1, registered "some driver owned the bus".
- owner, output, $clog2(NDRV), registered index of the winning driver.
- contention, output, 1, sticky flag: 2 or more drivers asserted in the same cycle.
- contMask, output, NDRV, drvDriving snapshot from the first contention since the last clear.
- contCount, output, CW, saturating count of contention cycles.
- holdTimeout, output, 1, sticky flag: one owner drove for MAXHOLD consecutive cycles.
- dataPar, output, 1, odd parity of data (see Optional Feature).

Behaviour:
- Reset (CROBAR sampled high at a clk edge) takes priority over every other input. All outputs go to 0 on that edge, including data, valid, owner, the flags, contMask, contCount, dataPar and the internal hold counter.
- Selection is combinational: win = lowest i with drvDriving[i] = 1.
- Registered update, 1-cycle latency:
  - If any driver is asserted: data <= drvData[win], owner <= win, valid <= 1.
  - If none is asserted: data <= 0, valid <= 0, owner holds its previous value.
- Contention is detected when popcount(drvDriving) >= 2 in a cycle. That cycle:
  - contention <= 1.
  - contCount <= contCount + 1, saturating at all-ones (no wrap).
  - contMask <= drvDriving only if contention was 0 before the edge; the first event is captured and later events do not overwrite it.
  - Data still follows the priority winner; contention never blocks the bus.
- Hold counter, internal, width $clog2(MAXHOLD+1):
  - Increments while valid-to-be is 1 and win equals the previous owner, with the previous valid = 1.
  - Loads 1 when a new owner takes the bus or the bus transitions from idle.
  - Clears to 0 when no driver is asserted.
  - When the counter reaches MAXHOLD, holdTimeout <= 1 (sticky) and the counter holds at MAXHOLD.
  - With MAXHOLD = 0 the counter is not built and holdTimeout stays 0.
- clrErr clears contention, contMask, contCount and holdTimeout. It does not affect the hold counter.
- clrErr in the same cycle as a new contention event: the clear applies first, then the event. Result: contention = 1, contCount = 1, contMask = current drvDriving.
- clrErr in the same cycle as a hold reaching MAXHOLD: holdTimeout = 1.
- Reset mid-hold or mid-contention: everything returns to 0 and the next cycle is treated as the bus coming out of idle.
- NDRV = 1 is legal. Contention can never fire; owner is 1 bit wide and constant 0.

Optional Feature:
- Macro: EBUS_PARITY_EN.
- Defined: dataPar is a register loaded in the same edge as data with ~^(next data), i.e. odd parity. It is 0 only in reset. Idle data = 0 gives dataPar = 1.
- Not defined: dataPar is tied to constant 0 and no parity logic is built. The port is always present so top wiring does not change.

Decomposition:
- Package ebus_pkg holds:
  - localparam EBUS_W = 36 and typedef ebusData_t = bit [0:EBUS_W-1].
  - Default NDRV and an enumerated driver-index constant list matching the top-level driver order (APR=0 … VMA=12), used for owner decode in the bench and the DTE.
- One sub-module, ebus_prio_enc (parameter NDRV). It outputs win, any (at least 1 asserted) and multi (at least 2 asserted). It is purely combinational and reused by the PI-level bus-request logic.

Test Plan:
- Reset: hold CROBAR 1 with drivers active, then release → all outputs 0 during reset; the first post-reset cycle reflects only post-reset inputs.
- Single driver: drvDriving[4] = 1 with data 36'o123456701234 → one cycle later data = 36'o123456701234, owner = 4, valid = 1, contention = 0. Drop request → data = 0, valid = 0, owner stays 4.
- Contention: drivers 2 and 9 asserted for 3 cycles, then 5 and 7 for 1 cycle → data from 2 and then 5, contCount = 4, contMask = bit2|bit9, contention = 1. A clrErr pulse → all cleared.
- Saturation and simultaneity:
  - CW = 2, 5 contention cycles → contCount = 3.
  - clrErr in the same cycle as contention on 0 and 1 → contCount = 1, contMask = bits 0|1.
- Hold timeout: MAXHOLD = 8, driver 6 held 7 cycles → holdTimeout = 0. On the 8th cycle → 1, and it stays 1 after the driver releases. With MAXHOLD = 0, 100 cycles → holdTimeout = 0.
- Parity:
  - EBUS_PARITY_EN defined, data 36'o000000000001 → dataPar = 0; data 0 → dataPar = 1.
  - Macro undefined → dataPar = 0 always.

Source files
------------

// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: data width, data type and the top-level driver index order.
package ebus_pkg;

    localparam int unsigned EBUS_W    = 36;
    localparam int unsigned EBUS_NDRV = 13;

    // Bit 0 is the MSB (PDP-10 0:35 numbering).
    typedef bit [0:EBUS_W-1] ebusData_t;

    typedef enum int unsigned {
        DrvApr = 0,
        DrvCon = 1,
        DrvCra = 2,
        DrvCtl = 3,
        DrvDte = 4,
        DrvEdp = 5,
        DrvIr  = 6,
        DrvMbz = 7,
        DrvMtr = 8,
        DrvPic = 9,
        DrvScd = 10,
        DrvShm = 11,
        DrvVma = 12
    } ebus_drv_e;

endpackage

// File: rtl/ebus_arb_mux_if.sv
// EBUS driver-side inputs and registered mux outputs; master drives the requests, slave is the mux.
interface ebus_arb_mux_if #(
    parameter int unsigned NDRV = 13,
    parameter int unsigned W    = 36,
    parameter int unsigned CW   = 8
);
    localparam int unsigned OW = (NDRV > 1) ? $clog2(NDRV) : 1;

    logic [NDRV-1:0]   drvDriving;
    logic [NDRV*W-1:0] drvData;
    logic              clrErr;
    logic [0:W-1]      data;
    logic              valid;
    logic [OW-1:0]     owner;
    logic              contention;
    logic [NDRV-1:0]   contMask;
    logic [CW-1:0]     contCount;
    logic              holdTimeout;
    logic              dataPar;

    modport master (
        output drvDriving, drvData, clrErr,
        input  data, valid, owner, contention, contMask, contCount, holdTimeout, dataPar
    );

    modport slave (
        input  drvDriving, drvData, clrErr,
        output data, valid, owner, contention, contMask, contCount, holdTimeout, dataPar
    );

endinterface

// File: rtl/ebus_prio_enc.sv
// Fixed-priority encoder: lowest asserted index wins; also flags one-or-more and two-or-more requests.
module ebus_prio_enc #(
    parameter  int unsigned NDRV = 13,
    localparam int unsigned OW   = (NDRV > 1) ? $clog2(NDRV) : 1
) (
    input  logic [NDRV-1:0] req,
    output logic [OW-1:0]   win,
    output logic            any,
    output logic            multi
);

    always_comb begin
        win   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < NDRV; i++) begin
            if (req[i]) begin
                if (!any) win = OW'(i);
                multi = multi | any;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ebus_arb_mux.sv
// EBUS priority mux with 1-cycle registered output, contention capture and stuck-driver timeout.
// Define EBUS_PARITY_EN to build the registered odd-parity output dataPar (tied 0 otherwise).
module ebus_arb_mux
    import ebus_pkg::*;
#(
    parameter int unsigned NDRV    = EBUS_NDRV,
    parameter int unsigned W       = EBUS_W,
    parameter int unsigned CW      = 8,
    parameter int unsigned MAXHOLD = 1024
) (
    input logic           clk,
    input logic           CROBAR,
    ebus_arb_mux_if.slave bus
);

    localparam int unsigned OW = (NDRV > 1) ? $clog2(NDRV) : 1;

    logic [OW-1:0]   win;
    logic            any;
    logic            multi;
    logic [0:W-1]    data_d;
    logic [0:W-1]    data_q;
    logic            valid_q;
    logic [OW-1:0]   owner_q;
    logic            cont_q;
    logic [NDRV-1:0] mask_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_inc;
    logic            hold_to_q;
    logic            par;

    ebus_prio_enc #(
        .NDRV(NDRV)
    ) u_prio_enc (
        .req  (bus.drvDriving),
        .win  (win),
        .any  (any),
        .multi(multi)
    );

    assign data_d    = any ? bus.drvData[int'(win)*W +: W] : '0;
    assign count_inc = (&count_q) ? count_q : count_q + CW'(1);

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
            cont_q  <= 1'b0;
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= any;
            if (any) owner_q <= win;
            // A clear in the same cycle as an event is applied first, so the event is recaptured.
            if (multi) begin
                cont_q  <= 1'b1;
                if (!cont_q || bus.clrErr) mask_q <= bus.drvDriving;
                count_q <= bus.clrErr ? CW'(1) : count_inc;
            end else if (bus.clrErr) begin
                cont_q  <= 1'b0;
                mask_q  <= '0;
                count_q <= '0;
            end
        end
    end

    if (MAXHOLD > 0) begin : g_hold
        localparam int unsigned HW = $clog2(MAXHOLD + 1);
        logic [HW-1:0] hold_q;
        logic [HW-1:0] hold_d;

        always_comb begin
            hold_d = hold_q;
            if (!any) begin
                hold_d = '0;
            end else if (valid_q && (win == owner_q)) begin
                if (hold_q != HW'(MAXHOLD)) hold_d = hold_q + HW'(1);
            end else begin
                hold_d = HW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (CROBAR) begin
                hold_q    <= '0;
                hold_to_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                if (hold_d == HW'(MAXHOLD)) hold_to_q <= 1'b1;
                else if (bus.clrErr)        hold_to_q <= 1'b0;
            end
        end
    end else begin : g_no_hold
        assign hold_to_q = 1'b0;
    end

`ifdef EBUS_PARITY_EN
    always_ff @(posedge clk) begin
        if (CROBAR) par <= 1'b0;
        else        par <= ~^data_d;
    end
`else
    assign par = 1'b0;
`endif

    assign bus.data        = data_q;
    assign bus.valid       = valid_q;
    assign bus.owner       = owner_q;
    assign bus.contention  = cont_q;
    assign bus.contMask    = mask_q;
    assign bus.contCount   = count_q;
    assign bus.holdTimeout = hold_to_q;
    assign bus.dataPar     = par;

endmodule

// File: tb/tb_ebus_arb_mux.sv
// Scoreboard bench: two mux instances (CW=8/MAXHOLD=8 and CW=2/MAXHOLD=0) share one stimulus stream.
module tb_ebus_arb_mux;
    import ebus_pkg::*;

    typedef enum int {
        FData, FValid, FOwner, FCont, FMask, FCount, FHold, FPar, FBCount, FBHold
    } field_e;

    typedef struct {
        int          at;
        field_e      f;
        logic [63:0] v;
        string       nm;
    } exp_t;

`ifdef EBUS_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        CROBAR = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [35:0] dd[13];

    ebus_arb_mux_if #(.NDRV(13), .W(36), .CW(8)) if_a ();
    ebus_arb_mux_if #(.NDRV(13), .W(36), .CW(2)) if_b ();

    assign if_b.drvDriving = if_a.drvDriving;
    assign if_b.drvData    = if_a.drvData;
    assign if_b.clrErr     = if_a.clrErr;

    ebus_arb_mux #(.NDRV(13), .W(36), .CW(8), .MAXHOLD(8)) u_dut_a (
        .clk   (clk),
        .CROBAR(CROBAR),
        .bus   (if_a.slave)
    );

    ebus_arb_mux #(.NDRV(13), .W(36), .CW(2), .MAXHOLD(0)) u_dut_b (
        .clk   (clk),
        .CROBAR(CROBAR),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(input field_e f);
        case (f)
            FData:   return 64'(if_a.data);
            FValid:  return 64'(if_a.valid);
            FOwner:  return 64'(if_a.owner);
            FCont:   return 64'(if_a.contention);
            FMask:   return 64'(if_a.contMask);
            FCount:  return 64'(if_a.contCount);
            FHold:   return 64'(if_a.holdTimeout);
            FPar:    return 64'(if_a.dataPar);
            FBCount: return 64'(if_b.contCount);
            FBHold:  return 64'(if_b.holdTimeout);
            default: return 64'hdead;
        endcase
    endfunction

    // Monitor: compare every expectation due at this cycle, flag any that went stale.
    initial begin
        exp_t e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e   = sb.pop_front();
                act = actual(e.f);
                n_cmp++;
                if (e.at != cyc || act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %0h want %0h (due cycle %0d, checked %0d)",
                             e.nm, act, e.v, e.at, cyc);
                end
            end
        end
    end

    task automatic pack();
        for (int i = 0; i < 13; i++) if_a.drvData[i*36 +: 36] = dd[i];
    endtask

    // Inputs applied just after an edge take effect at the next edge; expectations target it.
    task automatic step(input logic [12:0] drv, input bit clr, input bit rst);
        @(posedge clk);
        #1;
        CROBAR          = rst;
        if_a.drvDriving = drv;
        if_a.clrErr     = clr;
    endtask

    task automatic ex(input field_e f, input logic [63:0] v, input string nm);
        exp_t e;
        e.at = cyc + 1;
        e.f  = f;
        e.v  = v;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic ex_all(input logic [35:0] d, input bit v, input int o, input bit c,
                          input logic [12:0] m, input int cnt, input bit h, input string nm);
        ex(FData,  64'(d),   {nm, ".data"});
        ex(FValid, 64'(v),   {nm, ".valid"});
        ex(FOwner, 64'(o),   {nm, ".owner"});
        ex(FCont,  64'(c),   {nm, ".contention"});
        ex(FMask,  64'(m),   {nm, ".contMask"});
        ex(FCount, 64'(cnt), {nm, ".contCount"});
        ex(FHold,  64'(h),   {nm, ".holdTimeout"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 13; i++) dd[i] = '0;
        dd[0] = 36'o000000000001;
        dd[1] = 36'o777777777777;
        dd[2] = 36'o222222222222;
        dd[4] = 36'o123456701234;
        dd[5] = 36'o555555555555;
        dd[6] = 36'o666666666666;
        dd[7] = 36'o707070707070;
        dd[9] = 36'o111111111111;
        if_a.drvDriving = '0;
        if_a.clrErr     = 1'b0;
        pack();

        // Reset held with drivers (including contention) active.
        step(13'h014, 1'b0, 1'b1);
        ex_all(36'o0, 0, 0, 0, 13'h0, 0, 0, "rst0");
        ex(FPar, 64'(0), "rst0.dataPar");
        step(13'h204, 1'b0, 1'b1);
        ex_all(36'o0, 0, 0, 0, 13'h0, 0, 0, "rst1");
        ex(FBCount, 64'(0), "rst1.b.contCount");

        // Single driver 4, then release: owner must hold.
        step(13'h010, 1'b0, 1'b0);
        ex_all(36'o123456701234, 1, DrvDte, 0, 13'h0, 0, 0, "single");
        step(13'h000, 1'b0, 1'b0);
        ex_all(36'o0, 0, DrvDte, 0, 13'h0, 0, 0, "release");
        ex(FPar, 64'(ParEn), "idle.dataPar");

        // Contention on 2|9 for 3 cycles, then 5|7 for 2 cycles.
        for (int k = 1; k <= 3; k++) begin
            step(13'h204, 1'b0, 1'b0);
            ex_all(36'o222222222222, 1, DrvCra, 1, 13'h204, k, 0, $sformatf("cont29_%0d", k));
            ex(FBCount, 64'(k), $sformatf("cont29_%0d.b.contCount", k));
        end
        step(13'h0a0, 1'b0, 1'b0);
        ex_all(36'o555555555555, 1, DrvEdp, 1, 13'h204, 4, 0, "cont57_1");
        ex(FBCount, 64'(3), "cont57_1.b.contCount");
        step(13'h0a0, 1'b0, 1'b0);
        ex(FCount, 64'(5), "cont57_2.contCount");
        ex(FBCount, 64'(3), "sat.b.contCount");

        // Clear pulse on an idle bus.
        step(13'h000, 1'b1, 1'b0);
        ex_all(36'o0, 0, DrvEdp, 0, 13'h0, 0, 0, "clr");
        ex(FBCount, 64'(0), "clr.b.contCount");

        // Clear coinciding with a new contention event.
        step(13'h108, 1'b0, 1'b0);
        ex_all(36'o0, 1, DrvCtl, 1, 13'h108, 1, 0, "cont38");
        step(13'h003, 1'b1, 1'b0);
        ex_all(36'o000000000001, 1, DrvApr, 1, 13'h003, 1, 0, "clr_cont01");
        ex(FPar, 64'(0), "par1.dataPar");
        ex(FBCount, 64'(1), "clr_cont01.b.contCount");
        step(13'h000, 1'b1, 1'b0);
        ex_all(36'o0, 0, DrvApr, 0, 13'h0, 0, 0, "clr2");

        // Hold timeout: 7 cycles below threshold, 8th trips it, stays sticky after release.
        for (int k = 1; k <= 7; k++) step(13'h040, 1'b0, 1'b0);
        ex_all(36'o666666666666, 1, DrvIr, 0, 13'h0, 0, 0, "hold7");
        step(13'h040, 1'b0, 1'b0);
        ex(FHold, 64'(1), "hold8.holdTimeout");
        ex(FBHold, 64'(0), "hold8.b.holdTimeout");
        step(13'h000, 1'b0, 1'b0);
        step(13'h000, 1'b0, 1'b0);
        ex_all(36'o0, 0, DrvIr, 0, 13'h0, 0, 1, "hold_sticky");

        // Clear coinciding with the hold reaching the limit: flag still set.
        step(13'h000, 1'b1, 1'b0);
        ex(FHold, 64'(0), "hold_clr.holdTimeout");
        for (int k = 1; k <= 7; k++) step(13'h040, 1'b0, 1'b0);
        ex(FHold, 64'(0), "hold7b.holdTimeout");
        step(13'h040, 1'b1, 1'b0);
        ex(FHold, 64'(1), "hold_clr8.holdTimeout");

        // Reset mid-hold and mid-contention, then treat the bus as coming out of idle.
        step(13'h0c0, 1'b0, 1'b1);
        ex_all(36'o0, 0, 0, 0, 13'h0, 0, 0, "rst_mid");
        step(13'h040, 1'b0, 1'b0);
        ex_all(36'o666666666666, 1, DrvIr, 0, 13'h0, 0, 0, "post_rst");

        // Long hold: MAXHOLD=8 instance times out, MAXHOLD=0 instance never does.
        for (int k = 1; k <= 100; k++) step(13'h040, 1'b0, 1'b0);
        ex(FHold, 64'(1), "long.holdTimeout");
        ex(FBHold, 64'(0), "long.b.holdTimeout");

        step(13'h000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
